// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//   Frame-level pixel stream transmitter for the feature-detection pipeline.
//   A start pulse in IDLE emits one frame of LINES lines. Each line is
//   ACTIVE_W valid pixels followed by BLANK_W blanking cycles. A one-cycle
//   done pulse follows the last line. Pixel values come from a pattern
//   selected by mode, which is latched at start.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   begin a frame (sampled only in IDLE)
//   mode[1:0]  in   pattern: 0 const, 1 x ramp, 2 x+y ramp, 3 8x8 checker
//   const_val  in   pixel value for mode 0
//   pause      in   freezes the stream in ACTIVE/BLANK while high
//   dout[7:0]  out  pixel data (0 when not an active pixel)
//   valid      out  dout carries an active pixel
//   sol/eol    out  first/last pixel of a line
//   sof/eof    out  first/last pixel of the frame
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the frame completes
module pixel_stream_source #(
  parameter int ACTIVE_W = 800,
  parameter int BLANK_W  = 100,
  parameter int LINES    = 10,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] const_val,
  input  logic       pause,
  output logic [7:0] dout,
  output logic       valid,
  output logic       sol,
  output logic       eol,
  output logic       sof,
  output logic       eof,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_BLANK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [XW-1:0] X_ALAST = XW'(ACTIVE_W - 1);
  // Guarded so a zero-length blanking interval does not build a negative constant.
  localparam logic [XW-1:0] X_BLAST = XW'((BLANK_W > 0) ? BLANK_W - 1 : 0);
  localparam logic [YW-1:0] Y_LAST  = YW'(LINES - 1);

  logic [1:0]    state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [1:0]    mode_q;
  logic [7:0]    cval_q;

  logic          at_sol, at_eol, first_line, last_line, line_end, emit;
  logic [7:0]    x8, y8, pix;

  assign at_sol     = (x == '0);
  assign at_eol     = (x == X_ALAST);
  assign first_line = (y == '0);
  assign last_line  = (y == Y_LAST);
  assign emit       = (state == S_ACTIVE) && !pause;

  // Patterns only ever look at the low 8 bits of the coordinates.
  assign x8 = 8'(x);
  assign y8 = 8'(y);

  always_comb begin
    pix = 8'h00;
    case (mode_q)
      2'd0:    pix = cval_q;
      2'd1:    pix = x8;
      2'd2:    pix = x8 + y8;
      default: pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
    endcase
  end

  // Next-state / counter logic. In BLANK, x is reused as the blanking counter.
  // pause freezes x, y and state in ACTIVE and BLANK only.
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    line_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ACTIVE;
          x_n     = '0;
          y_n     = '0;
        end
      end
      S_ACTIVE: begin
        if (!pause) begin
          if (at_eol) begin
            if (BLANK_W > 0) begin
              state_n = S_BLANK;
              x_n     = '0;
            end else begin
              line_end = 1'b1;
            end
          end else begin
            x_n = x + 1'b1;
          end
        end
      end
      S_BLANK: begin
        if (!pause) begin
          if (x == X_BLAST) line_end = 1'b1;
          else              x_n      = x + 1'b1;
        end
      end
      default: state_n = S_IDLE;   // S_DONE lasts exactly one cycle
    endcase

    // Lines run back to back: no idle cycle between blanking and the next line.
    if (line_end) begin
      x_n = '0;
      if (last_line) begin
        state_n = S_DONE;
      end else begin
        y_n     = y + 1'b1;
        state_n = S_ACTIVE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      x      <= '0;
      y      <= '0;
      mode_q <= 2'd0;
      cval_q <= 8'h00;
      dout   <= 8'h00;
      valid  <= 1'b0;
      sol    <= 1'b0;
      eol    <= 1'b0;
      sof    <= 1'b0;
      eof    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;

      // Pixel outputs describe the coordinate being consumed this cycle.
      valid <= emit;
      dout  <= emit ? pix : 8'h00;
      sol   <= emit & at_sol;
      eol   <= emit & at_eol;
      sof   <= emit & at_sol & first_line;
      eof   <= emit & at_eol & last_line;

      done  <= (state == S_DONE);

      if (state == S_IDLE && start) begin
        mode_q <= mode;
        cval_q <= const_val;
        busy   <= 1'b1;
      end else if (state == S_DONE) begin
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source. Four instances cover the default
// geometry, a >256 line ramp, a no-blanking checkerboard and a one-pixel line.
// Expected pixels are pushed to a queue when a frame is started and popped by
// a monitor that watches the instance selected by sel.
module tb_pixel_stream_source;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]      start, pause, valid, sol, eol, sof, eof, busy, done;
  logic [3:0][1:0] mode;
  logic [3:0][7:0] cval, dout;

  pixel_stream_source #(.ACTIVE_W(800), .BLANK_W(100), .LINES(10), .XW(10), .YW(10)) u0 (
    .clock(clock), .reset(reset), .start(start[0]), .mode(mode[0]), .const_val(cval[0]),
    .pause(pause[0]), .dout(dout[0]), .valid(valid[0]), .sol(sol[0]), .eol(eol[0]),
    .sof(sof[0]), .eof(eof[0]), .busy(busy[0]), .done(done[0]));

  pixel_stream_source #(.ACTIVE_W(300), .BLANK_W(100), .LINES(2), .XW(9), .YW(2)) u1 (
    .clock(clock), .reset(reset), .start(start[1]), .mode(mode[1]), .const_val(cval[1]),
    .pause(pause[1]), .dout(dout[1]), .valid(valid[1]), .sol(sol[1]), .eol(eol[1]),
    .sof(sof[1]), .eof(eof[1]), .busy(busy[1]), .done(done[1]));

  pixel_stream_source #(.ACTIVE_W(16), .BLANK_W(0), .LINES(16), .XW(5), .YW(5)) u2 (
    .clock(clock), .reset(reset), .start(start[2]), .mode(mode[2]), .const_val(cval[2]),
    .pause(pause[2]), .dout(dout[2]), .valid(valid[2]), .sol(sol[2]), .eol(eol[2]),
    .sof(sof[2]), .eof(eof[2]), .busy(busy[2]), .done(done[2]));

  pixel_stream_source #(.ACTIVE_W(1), .BLANK_W(2), .LINES(3), .XW(2), .YW(2)) u3 (
    .clock(clock), .reset(reset), .start(start[3]), .mode(mode[3]), .const_val(cval[3]),
    .pause(pause[3]), .dout(dout[3]), .valid(valid[3]), .sol(sol[3]), .eol(eol[3]),
    .sof(sof[3]), .eof(eof[3]), .busy(busy[3]), .done(done[3]));

  // entry = {present, dout, sol, eol, sof, eof}
  typedef logic [12:0] ent_t;
  ent_t q[$];

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   sel = 0;
  logic clr = 1'b1;
  int   t_s;
  int   n_valid, n_sof, n_eof, n_done, first_cyc, done_cyc, done_prev;
  logic [7:0] last_eol_dout;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clock) begin
    ent_t got, want;
    if (clr) begin
      n_valid = 0; n_sof = 0; n_eof = 0; n_done = 0;
      first_cyc = 0; done_cyc = 0; done_prev = 0; last_eol_dout = 8'h00;
      q.delete();
    end else begin
      got = {valid[sel], dout[sel], sol[sel], eol[sel], sof[sel], eof[sel]};
      if (valid[sel]) begin
        if (n_valid == 0) first_cyc = cyc;
        n_valid++;
        if (sof[sel]) n_sof++;
        if (eof[sel]) n_eof++;
        if (eol[sel]) last_eol_dout = dout[sel];
        want = (q.size() != 0) ? q.pop_front() : 13'd0;
        chk("pixel", 32'(got), 32'(want));
      end else begin
        chk("flags_when_invalid", {28'd0, sol[sel], eol[sel], sof[sel], eof[sel]}, 32'd0);
      end
      if (done[sel]) begin
        done_prev = done_cyc;
        done_cyc  = cyc;
        n_done++;
        chk("busy_at_done", 32'(busy[sel]), 32'd0);
      end
    end
  end

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clock);
    #1 clr = 1'b0;
  endtask

  task automatic push_frame(input int a, input int l, input int md, input logic [7:0] cv);
    logic [7:0] d;
    for (int yy = 0; yy < l; yy++) begin
      for (int xx = 0; xx < a; xx++) begin
        case (md)
          0:       d = cv;
          1:       d = 8'(xx);
          2:       d = 8'(xx + yy);
          default: d = ((((xx / 8) ^ (yy / 8)) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
        q.push_back({1'b1, d, xx == 0, xx == a - 1, (xx == 0) && (yy == 0),
                     (xx == a - 1) && (yy == l - 1)});
      end
    end
  endtask

  // Start edge is recorded in t_s; the first pixel should follow one edge later.
  task automatic do_start(input int g, input logic [1:0] md, input logic [7:0] cv);
    @(negedge clock);
    mode[g] = md; cval[g] = cv; start[g] = 1'b1;
    @(posedge clock);
    #1 t_s = cyc;
    start[g] = 1'b0;
    @(negedge clock);
    chk("busy_after_start", 32'(busy[g]), 32'd1);
  endtask

  task automatic wait_done(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (n_done >= n) break;
      @(negedge clock);
    end
    chk("done_count", n_done, n);
  endtask

  initial begin
    int npause;
    int target;
    start = '0; pause = '0; mode = '0; cval = '0;

    // Reset state of every instance
    repeat (3) @(negedge clock);
    for (int g = 0; g < 4; g++)
      chk("reset_state", {20'd0, dout[g], valid[g], sol[g], eol[g], busy[g] | sof[g] | eof[g] | done[g]}, 32'd0);
    reset = 1'b0;

    // Default geometry, constant 8'h90
    sel = 0; do_clr();
    push_frame(800, 10, 0, 8'h90);
    do_start(0, 2'd0, 8'h90);
    wait_done(1, 10000);
    chk("t1_valid_count", n_valid, 8000);
    chk("t1_sof_count", n_sof, 1);
    chk("t1_eof_count", n_eof, 1);
    chk("t1_first_latency", first_cyc - t_s, 1);
    chk("t1_frame_time", done_cyc - first_cyc, 9000);
    chk("t1_queue_left", q.size(), 0);
    @(negedge clock);
    chk("t1_idle_after_done", {30'd0, busy[0], done[0]}, 32'd0);

    // Ramp wrapping past 256 on a 300-pixel line
    sel = 1; do_clr();
    push_frame(300, 2, 1, 8'h00);
    do_start(1, 2'd1, 8'h00);
    wait_done(1, 1000);
    chk("t2_valid_count", n_valid, 600);
    chk("t2_eol_dout", last_eol_dout, 43);
    chk("t2_frame_time", done_cyc - t_s, 2 * 400 + 1);
    chk("t2_queue_left", q.size(), 0);

    // Checkerboard, no blanking
    sel = 2; do_clr();
    push_frame(16, 16, 3, 8'h00);
    do_start(2, 2'd3, 8'h00);
    wait_done(1, 400);
    chk("t3_valid_count", n_valid, 256);
    chk("t3_frame_time", done_cyc - t_s, 257);
    chk("t3_queue_left", q.size(), 0);

    // One-pixel lines: sol and eol together
    sel = 3; do_clr();
    push_frame(1, 3, 2, 8'h00);
    do_start(3, 2'd2, 8'h00);
    wait_done(1, 100);
    chk("t4_valid_count", n_valid, 3);
    chk("t4_frame_time", done_cyc - t_s, 3 * 3 + 1);
    chk("t4_sof_eof", {n_sof[15:0], n_eof[15:0]}, {16'd1, 16'd1});

    // Random pause in mode 2; mid-frame mode/const changes must be ignored
    sel = 0; do_clr();
    push_frame(800, 10, 2, 8'h00);
    do_start(0, 2'd2, 8'h00);
    npause = 0;
    for (int i = 0; i < 2000; i++) begin
      pause[0] = ($urandom_range(0, 3) == 0);
      if (pause[0]) npause++;
      if (i == 10) begin mode[0] = 2'd0; cval[0] = 8'h55; end
      @(negedge clock);
    end
    pause[0] = 1'b0;
    wait_done(1, 12000);
    chk("t5_valid_count", n_valid, 8000);
    chk("t5_frame_time", done_cyc - t_s, 9001 + npause);
    chk("t5_queue_left", q.size(), 0);

    // Reset at pixel (400,3)
    do_clr();
    push_frame(800, 10, 0, 8'h3C);
    do_start(0, 2'd0, 8'h3C);
    target = t_s + 1 + 3 * 900 + 400;
    while (cyc < target) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("t6_outputs_after_reset",
        {22'd0, dout[0], valid[0], sol[0] | eol[0] | sof[0] | eof[0]}, 32'd0);
    chk("t6_busy_done_after_reset", {30'd0, busy[0], done[0]}, 32'd0);
    chk("t6_pixels_before_reset", q.size(), 8000 - 2801);
    repeat (1000) @(negedge clock);
    chk("t6_no_done_after_reset", n_done, 0);

    // Fresh frame; a start while busy is ignored
    do_clr();
    push_frame(800, 10, 1, 8'h00);
    do_start(0, 2'd1, 8'h00);
    repeat (500) @(negedge clock);
    mode[0] = 2'd3; start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    wait_done(1, 10000);
    chk("t6_fresh_sof", n_sof, 1);
    chk("t6_fresh_valid", n_valid, 8000);
    chk("t6_fresh_time", done_cyc - t_s, 9001);
    chk("t6_queue_left", q.size(), 0);

    // start held high: three back-to-back frames, one IDLE cycle between
    sel = 2; do_clr();
    for (int f = 0; f < 3; f++) push_frame(16, 16, 3, 8'h00);
    @(negedge clock);
    mode[2] = 2'd3; start[2] = 1'b1;
    @(posedge clock);
    #1 t_s = cyc;
    while (cyc < t_s + 2 * 258) @(negedge clock);
    start[2] = 1'b0;
    wait_done(3, 1000);
    chk("t7_sof_count", n_sof, 3);
    chk("t7_valid_count", n_valid, 768);
    chk("t7_done_spacing", done_cyc - done_prev, 258);
    chk("t7_last_done", done_cyc - t_s, 516 + 257);
    chk("t7_queue_left", q.size(), 0);
    repeat (300) @(negedge clock);
    chk("t7_no_extra_frame", n_done, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
